// File: rtl/colour_button_decoder.sv
`default_nettype none
// ============================================================================
// colour_button_decoder: synchronises and debounces four player buttons and
// emits a 2-bit colour code with a valid strobe.
// Optional feature macro: COLOUR_DEC_HOLD_EN (valid held until ack).
// Revision: 1.0
// ============================================================================
module colour_button_decoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ie,
   input  logic [3:0] btn,
   input  logic       ack,
   output logic [1:0] colour_out,
   output logic       colour_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1;
   logic [3:0]       s;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [3:0]       cand;
   logic [3:0]       cand_next;
   logic             accept;
   logic             valid_next;
   logic             onehot;

   function automatic logic [1:0] encode(input logic [3:0] v);
      logic [1:0] code;
      code = 2'b00;
      if (v[3])      code = 2'b11;
      else if (v[2]) code = 2'b10;
      else if (v[1]) code = 2'b01;
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 4'd0;
         s     <= 4'd0;
      end else begin
         sync1 <= btn;
         s     <= sync1;
      end
   end

   assign onehot = (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cand_next  = cand;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (ie && onehot) begin
               cand_next  = s;
               cnt_next   = '0;
               state_next = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (!ie || (s != cand)) begin
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               accept     = 1'b1;
               state_next = HELD;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (s == 4'd0) begin
               cnt_next   = '0;
               state_next = DEB_REL;
            end
         end
         DEB_REL: begin
            // Any bounce back to a pressed level restarts the release debounce.
            if (s != 4'd0) begin
               state_next = HELD;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef COLOUR_DEC_HOLD_EN
   // A fresh acceptance outranks an ack arriving in the same cycle.
   assign valid_next = accept ? 1'b1 : (ack ? 1'b0 : colour_valid);
`else
   logic unused_ack;
   assign unused_ack = ack;
   assign valid_next = accept;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         cand         <= 4'd0;
         colour_out   <= 2'b00;
         colour_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         cand         <= cand_next;
         colour_valid <= valid_next;
         busy         <= (state_next != IDLE);
         if (accept) colour_out <= encode(cand);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_colour_button_decoder.sv
`default_nettype none
// Testbench for colour_button_decoder (DEBOUNCE_CYCLES=4, CNT_W=3).
// Scoreboard: expected colours are queued when a press is driven, popped on valid.
module tb_colour_button_decoder;

   logic       clk;
   logic       reset;
   logic       ie;
   logic [3:0] btn;
   logic       ack;
   logic [1:0] colour_out;
   logic       colour_valid;
   logic       busy;

   int         errors = 0;
   int         checks = 0;
   logic [1:0] exp_q[$];
   logic       prev_valid = 1'b0;

   colour_button_decoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .ie(ie), .btn(btn), .ack(ack),
      .colour_out(colour_out), .colour_valid(colour_valid), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard monitor: every new acceptance must match the oldest expectation.
   always @(negedge clk) begin
      logic       fire;
      logic [1:0] expv;
`ifdef COLOUR_DEC_HOLD_EN
      fire = colour_valid && !prev_valid;
`else
      fire = colour_valid;
`endif
      prev_valid = colour_valid;
      if (fire) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: colour_out=%b, no press expected", colour_out);
         end else begin
            expv = exp_q.pop_front();
            if (colour_out !== expv) begin
               errors++;
               $display("FAIL colour_code: got %b expected %b", colour_out, expv);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy === 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b expected 0 within %0d cycles", busy, max_cycles);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_valid: %0d pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn   = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            reset = 1'b0;
            btn   = 4'b0000;
         end
         tick();
         checks++;
         if (colour_out !== 2'b00 || colour_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values[%0d]: out=%b valid=%b busy=%b expected 00/0/0",
                     i, colour_out, colour_valid, busy);
         end
      end
   endtask

   task automatic test_clean_press();
      int first, pulses;
      first = 0; pulses = 0;
      btn = 4'b0100;
      exp_q.push_back(2'b10);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (colour_valid) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL clean_latency: pulse at edge %0d expected 7", first);
      end
      btn = 4'b0000;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (busy === 1'b0 && first == 0) first = k;
         if (colour_valid) pulses++;
      end
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL clean_release: busy low at edge %0d expected 7", first);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL clean_pulse_count: got %0d expected 1", pulses);
      end
      check_drained("clean");
   endtask

   task automatic test_bounce();
      int first, early;
      first = 0; early = 0;
      btn = 4'b0001; tick(); tick();
      if (colour_valid) early++;
      btn = 4'b0000; tick();
      if (colour_valid) early++;
      btn = 4'b0001;
      exp_q.push_back(2'b00);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (colour_valid && first == 0) first = k;
      end
      checks++;
      if (early != 0 || first != 7) begin
         errors++;
         $display("FAIL bounce: early=%0d pulse_edge=%0d expected 0 and 7", early, first);
      end
      btn = 4'b0000;
      wait_idle(20);
      check_drained("bounce");
   endtask

   task automatic test_multi_disable();
      int bad, first;
      bad = 0; first = 0;
      btn = 4'b1010;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (colour_valid || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL multi_press: %0d active cycles expected 0", bad);
      end
      btn = 4'b0000; tick(); tick(); tick();
      ie = 1'b0; btn = 4'b1000; bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (colour_valid || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ie_low: %0d active cycles expected 0", bad);
      end
      ie = 1'b1;
      exp_q.push_back(2'b11);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (colour_valid && first == 0) first = k;
      end
      checks++;
      if (first != 5) begin
         errors++;
         $display("FAIL ie_raise: pulse at edge %0d expected 5", first);
      end
      btn = 4'b0000;
      wait_idle(20);
      check_drained("ie_raise");
   endtask

   task automatic test_release_bounce();
      int first, idle_k, green_k, dropped;
      first = 0; idle_k = 0; green_k = 0; dropped = 0;
      btn = 4'b0010;
      exp_q.push_back(2'b01);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (colour_valid && first == 0) first = k;
      end
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL blue_latency: pulse at edge %0d expected 7", first);
      end
      for (int t = 0; t < 4; t++) begin
         btn = (t % 2 == 0) ? 4'b0000 : 4'b0010;
         tick();
         if (busy !== 1'b1) dropped++;
      end
      btn = 4'b0000;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (busy === 1'b0 && idle_k == 0) idle_k = k;
         if (colour_valid && green_k == 0) green_k = k;
         if (k == 5) begin
            btn = 4'b1000;
            exp_q.push_back(2'b11);
         end
      end
      checks++;
      if (dropped != 0 || idle_k != 7) begin
         errors++;
         $display("FAIL release_bounce: dropped=%0d idle_edge=%0d expected 0 and 7", dropped, idle_k);
      end
      checks++;
      if (green_k != 12) begin
         errors++;
         $display("FAIL late_green: pulse at edge %0d expected 12", green_k);
      end
      btn = 4'b0000;
      wait_idle(20);
      check_drained("release_bounce");
   endtask

   task automatic test_reset_mid();
      int first;
      first = 0;
      btn = 4'b1000;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || colour_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b valid=%b expected 0/0", busy, colour_valid);
      end
      reset = 1'b0;
      exp_q.push_back(2'b11);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (colour_valid && first == 0) first = k;
      end
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL reset_held_press: pulse at edge %0d expected 7", first);
      end
      btn = 4'b0000;
      wait_idle(20);
      check_drained("reset_mid");
   endtask

`ifdef COLOUR_DEC_HOLD_EN
   task automatic test_hold();
      int n, bad;
      ack = 1'b0;
      btn = 4'b0001;
      exp_q.push_back(2'b00);
      n = 0;
      while (colour_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (colour_valid !== 1'b1) bad++;
      end
      checks++;
      if (n >= 12 || bad != 0) begin
         errors++;
         $display("FAIL hold_valid: wait=%0d drops=%0d expected <12 and 0", n, bad);
      end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++;
      if (colour_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack: valid=%b expected 0", colour_valid);
      end
      btn = 4'b0000;
      wait_idle(20);
      btn = 4'b0001;
      exp_q.push_back(2'b00);
      n = 0;
      while (colour_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      reset = 1'b1; tick(); reset = 1'b0;
      btn = 4'b0000;
      checks++;
      if (colour_valid !== 1'b0 || n >= 12) begin
         errors++;
         $display("FAIL hold_reset: valid=%b wait=%0d expected 0 and <12", colour_valid, n);
      end
      tick();
      ack = 1'b1;
      check_drained("hold");
   endtask
`endif

   initial begin
      reset = 1'b1; ie = 1'b1; btn = 4'b0000; ack = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_multi_disable();
      test_release_bounce();
      test_reset_mid();
`ifdef COLOUR_DEC_HOLD_EN
      test_hold();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/colour_button_decoder.md
Name: colour_button_decoder

Overview:
- Input-side counterpart of the LED colour encoder: converts four raw player buttons (red, blue, yellow, green) into the 2-bit colour code used by the game controller, plus a valid strobe.
- Synchronises and debounces the buttons, accepts exactly one pressed button, and requires a debounced release before the next press is accepted.
- Sits between the ui_in button pins and the Simon Says sequence-compare logic.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronised samples needed to accept a press or a release (legal range ≥2).
- CNT_W, 5, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ie  input  1  active-high input enable; presses are ignored while low.
- btn  input  4  raw asynchronous buttons, active high: [0]=red, [1]=blue, [2]=yellow, [3]=green.
- ack  input  1  consumer acknowledge; used only with COLOUR_DEC_HOLD_EN, ignored otherwise.
- colour_out  output  2  colour code: 00=red, 01=blue, 10=yellow, 11=green.
- colour_valid  output  1  colour_out carries a new accepted press.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything): synchroniser flops=0, state=IDLE, cnt=0, cand=0, colour_out=00, colour_valid=0, busy=0.
- Synchroniser: two flops per bit on btn; s[3:0] is the second-stage output. All FSM decisions use s only.
- onehot: s has exactly one bit set. s=0 or two or more bits set is not onehot.
- State IDLE: if ie && onehot, then cand<=s, cnt<=0, go to DEB_PRESS. Otherwise remain in IDLE, including when several buttons are pressed.
- State DEB_PRESS:
  - If !ie or s!=cand, go to IDLE.
  - Else if cnt==DEBOUNCE_CYCLES-1, register colour_out<=encode(cand), pulse colour_valid, go to HELD.
  - Else cnt<=cnt+1.
- State HELD: if s==0, then cnt<=0, go to DEB_REL. Otherwise wait, whatever the values of s and ie.
- State DEB_REL:
  - If s!=0, go to HELD. A bounce restarts the release debounce.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
  - Else cnt<=cnt+1.
- ie low during HELD or DEB_REL does not abort the release; this prevents a held button producing a fresh press when ie returns high.
- Latency: raw btn stable from edge E0 gives colour_valid high after edge E0+DEBOUNCE_CYCLES+2, i.e. on the (DEBOUNCE_CYCLES+3)th edge.
- colour_valid (default build): single-cycle pulse.
- colour_out holds the last accepted colour until the next accepted press.
- busy is registered with the state and equals (state!=IDLE).
- Counter never wraps: it is cleared on every entry to a debounce state and stops at DEBOUNCE_CYCLES-1.
- Reset mid-operation: returns to IDLE next edge; any pending valid is dropped. A button still held after reset is treated as a new press once debounced.

Optional Feature:
- COLOUR_DEC_HOLD_EN defined:
  - colour_valid is set on acceptance and stays high until a cycle with ack=1; it clears on the edge after that cycle.
  - If ack=1 in the same cycle as a new acceptance, the new acceptance wins and valid stays high with the new colour_out.
  - ack while colour_valid=0 has no effect.
- COLOUR_DEC_HOLD_EN undefined: colour_valid is a one-cycle pulse and ack is ignored.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset values: assert reset 2 cycles with btn=4'b1111 -> colour_out=00, colour_valid=0, busy=0 throughout and on the first cycle after release.
- Clean press: ie=1, btn=4'b0100 held 20 cycles then 0 -> exactly one colour_valid pulse on the 7th edge after btn rises, colour_out=10; busy falls 4+ cycles after s clears; no second pulse.
- Bounce: btn=4'b0001 for 2 cycles, 0 for 1 cycle, then stable -> no pulse during the bounce; a single pulse with colour_out=00 once stable for 4 samples.
- Multi-press and disable:
  - btn=4'b1010 for 20 cycles -> no colour_valid, state stays IDLE.
  - ie=0 with btn=4'b1000 -> no colour_valid.
  - ie raised while btn=4'b1000 is held -> pulse with colour_out=11.
- Release bounce: after accepting blue (01), toggle btn[1] 1-0-1-0 every cycle, then 0 -> stays busy until 4 clean zero samples; a green press arriving 1 cycle before release debounce completes is ignored until the FSM returns to IDLE.
- COLOUR_DEC_HOLD_EN: accept red, keep ack=0 for 10 cycles -> colour_valid stays 1; ack=1 for one cycle -> colour_valid=0 on the next edge. Reset while valid -> colour_valid=0.
